aer_spike_encoder: RTL and testbench

Downstream stage for an array of LIF neurons. Converts each neuron's level-type spike output into a single address-event (AER) per rising edge. Each event is tagged with a timestamp, arbitrated round-robin, and buffered in a FIFO. Events leave on a valid/ready stream toward the chip output mux or serializer.

---
 rtl/aer_spike_encoder.sv | 147 ++++++++++++++
 tb/tb_aer_spike_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_encoder.sv
// rtl/aer_spike_encoder.sv - spike rising edges to timestamped AER events, round-robin arbitration, event FIFO
module aer_spike_encoder #(
   parameter int N_NEURONS  = 4,
   parameter int ADDR_W     = 2,
   parameter int TS_W       = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [N_NEURONS-1:0] spike_in,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [ADDR_W-1:0]    ev_addr,
   output logic [TS_W-1:0]      ev_ts,
   output logic                 overflow,
   output logic [7:0]           drop_cnt,
   output logic [TS_W-1:0]      ts_now
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [N_NEURONS-1:0]   prev;
   logic [N_NEURONS-1:0]   pend;
   logic [N_NEURONS-1:0]   rise;
   logic [N_NEURONS-1:0]   grant_oh;
   logic [N_NEURONS-1:0]   drop_vec;
   logic [N_NEURONS-1:0]   pend_rot;
   logic [2*N_NEURONS-1:0] pend_dbl;
   logic [TS_W-1:0]        ts_lat [N_NEURONS];
   logic [ADDR_W-1:0]      rr_ptr;
   logic [ADDR_W-1:0]      rr_next;
   logic [ADDR_W-1:0]      grant_off;
   logic [ADDR_W:0]        grant_sum;
   logic [ADDR_W-1:0]      grant_idx;
   logic                   grant_vld;

   logic [ADDR_W-1:0]      fifo_addr [FIFO_DEPTH];
   logic [TS_W-1:0]        fifo_ts   [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   fifo_full;
   logic                   push;
   logic                   pop;

   logic [4:0]             drop_n;
   logic [8:0]             drop_sum;
   logic [7:0]             drop_next;

   assign rise      = en ? (spike_in & ~prev) : '0;
   assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
   assign ev_valid  = (count != '0);
   assign pop       = ev_valid & ev_ready;
   assign push      = grant_vld;
   assign ev_addr   = ev_valid ? fifo_addr[rd_ptr] : '0;
   assign ev_ts     = ev_valid ? fifo_ts[rd_ptr] : '0;

   // Rotate pend so bit 0 is rr_ptr; the first set bit is the round-robin winner.
   always_comb begin
      pend_dbl  = {pend, pend} >> rr_ptr;
      pend_rot  = pend_dbl[N_NEURONS-1:0];
      grant_vld = 1'b0;
      grant_off = '0;
      if (en && !fifo_full) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            if (!grant_vld && pend_rot[k]) begin
               grant_vld = 1'b1;
               grant_off = ADDR_W'(k);
            end
         end
      end
      grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
      if (grant_sum >= (ADDR_W+1)'(N_NEURONS)) begin
         grant_sum = grant_sum - (ADDR_W+1)'(N_NEURONS);
      end
      grant_idx = grant_sum[ADDR_W-1:0];
      grant_oh  = grant_vld ? ({{(N_NEURONS-1){1'b0}}, 1'b1} << grant_idx) : '0;
      rr_next   = (grant_idx == ADDR_W'(N_NEURONS-1)) ? '0 : grant_idx + 1'b1;
   end

   // A rise on a still-pending neuron is lost unless that neuron is granted this edge.
   always_comb begin
      drop_vec = rise & pend & ~grant_oh;
      drop_n   = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         drop_n = drop_n + {4'b0, drop_vec[i]};
      end
      drop_sum  = {1'b0, drop_cnt} + {4'b0, drop_n};
      drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_now   <= '0;
         prev     <= '0;
         pend     <= '0;
         rr_ptr   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            ts_lat[i] <= '0;
         end
      end else begin
         if (en) begin
            ts_now <= ts_now + 1'b1;
            prev   <= spike_in;
            for (int i = 0; i < N_NEURONS; i++) begin
               if (rise[i] && (!pend[i] || grant_oh[i])) begin
                  pend[i]   <= 1'b1;
                  ts_lat[i] <= ts_now;
               end else if (grant_oh[i]) begin
                  pend[i] <= 1'b0;
               end
            end
            if (grant_vld) begin
               rr_ptr <= rr_next;
            end
         end
         if (|drop_vec) begin
            overflow <= 1'b1;
            drop_cnt <= drop_next;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         fifo_addr[wr_ptr] <= grant_idx;
         fifo_ts[wr_ptr]   <= ts_lat[grant_idx];
      end
   end
endmodule

// File: tb/tb_aer_spike_encoder.sv
// tb/tb_aer_spike_encoder.sv - directed and randomized checks of aer_spike_encoder against a queue-based event model
module tb_aer_spike_encoder;
   localparam int N     = 4;
   localparam int AW    = 2;
   localparam int TW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [N-1:0]  spike_in;
   logic          ev_valid;
   logic          ev_ready;
   logic [AW-1:0] ev_addr;
   logic [TW-1:0] ev_ts;
   logic          overflow;
   logic [7:0]    drop_cnt;
   logic [TW-1:0] ts_now;

   always #5 clk = ~clk;

   aer_spike_encoder #(
      .N_NEURONS(N), .ADDR_W(AW), .TS_W(TW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts),
      .overflow(overflow), .drop_cnt(drop_cnt), .ts_now(ts_now)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int m_ts;
   bit m_prev  [N];
   bit m_pend  [N];
   int m_tslat [N];
   int m_rr;
   int q_addr[$];
   int q_ts[$];
   int m_drop;
   bit m_ovf;
   bit model_live = 1'b0;
   int log_addr[$];
   int log_ts[$];

   task automatic check(string name, longint act, longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
   endtask

   // Event-level model: queues for the FIFO, plain arrays for pending state.
   task automatic model_step();
      int  g;
      bit  full;
      bit  do_pop;
      if (!rst_n) begin
         m_ts = 0; m_rr = 0; m_drop = 0; m_ovf = 0;
         q_addr.delete(); q_ts.delete();
         for (int i = 0; i < N; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_tslat[i] = 0;
         end
         model_live = 1'b1;
         return;
      end
      if (!model_live) return;
      g      = -1;
      full   = (q_addr.size() == DEPTH);
      do_pop = (q_addr.size() > 0) && ev_ready;
      if (en && !full) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
      end
      if (do_pop) begin
         void'(q_addr.pop_front());
         void'(q_ts.pop_front());
      end
      if (g >= 0) begin
         q_addr.push_back(g);
         q_ts.push_back(m_tslat[g]);
         m_pend[g] = 0;
         m_rr = (g + 1) % N;
      end
      if (en) begin
         for (int i = 0; i < N; i++) begin
            if (spike_in[i] && !m_prev[i]) begin
               if (!m_pend[i]) begin
                  m_pend[i]  = 1;
                  m_tslat[i] = m_ts;
               end else begin
                  m_ovf  = 1;
                  m_drop = (m_drop < 255) ? m_drop + 1 : 255;
               end
            end
            m_prev[i] = spike_in[i];
         end
         m_ts = (m_ts + 1) % 256;
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (model_live) begin
         check("ev_valid", ev_valid, q_addr.size() != 0);
         check("ev_addr", ev_addr, (q_addr.size() != 0) ? q_addr[0] : 0);
         check("ev_ts", ev_ts, (q_ts.size() != 0) ? q_ts[0] : 0);
         check("overflow", overflow, m_ovf);
         check("drop_cnt", drop_cnt, m_drop);
         check("ts_now", ts_now, m_ts);
      end
   end

   task automatic cycle(bit e, logic [N-1:0] s, bit r);
      en = e; spike_in = s; ev_ready = r;
      if (rst_n && ev_valid && ev_ready) begin
         log_addr.push_back(int'(ev_addr));
         log_ts.push_back(int'(ev_ts));
      end
      @(posedge clk);
      model_step();
      #3;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle(1'b1, '0, 1'b0);
      rst_n = 1'b1;
      log_addr.delete();
      log_ts.delete();
   endtask

   logic [N-1:0] rs;
   logic [N-1:0] flip;

   initial begin
      rst_n = 1'b0; en = 1'b0; spike_in = '0; ev_ready = 1'b0;
      #2;

      do_reset();
      check("reset_valid", ev_valid, 0);
      check("reset_ts", ts_now, 0);
      repeat (10) cycle(1, 4'b0000, 1);
      check("idle_ts", ts_now, 10);
      check("idle_model_ts", m_ts, 10);
      check("idle_valid", ev_valid, 0);
      check("idle_drop", drop_cnt, 0);
      check("idle_ovf", overflow, 0);

      do_reset();
      repeat (5) cycle(1, 4'b0000, 1);
      cycle(1, 4'b0100, 1);
      check("lat_k_valid", ev_valid, 0);
      cycle(1, 4'b0100, 1);
      check("lat_k1_valid", ev_valid, 1);
      check("lat_k1_addr", ev_addr, 2);
      check("lat_k1_ts", ev_ts, 5);
      cycle(1, 4'b0100, 1);
      check("lat_one_cycle", ev_valid, 0);
      repeat (18) cycle(1, 4'b0100, 1);
      repeat (2) cycle(1, 4'b0000, 1);
      check("held_count", log_addr.size(), 1);
      check("held_model_count", q_addr.size(), 0);

      do_reset();
      repeat (3) cycle(1, 4'b0000, 1);
      repeat (9) cycle(1, 4'b1111, 1);
      repeat (2) cycle(1, 4'b0000, 1);
      check("rr_count", log_addr.size(), 4);
      for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
         check("rr_addr", log_addr[i], i);
         check("rr_ts", log_ts[i], 3);
      end

      do_reset();
      cycle(1, 4'b1111, 0);
      repeat (4) cycle(1, 4'b0000, 0);
      cycle(1, 4'b1111, 0);
      repeat (4) cycle(1, 4'b0000, 0);
      cycle(1, 4'b1111, 0);
      cycle(1, 4'b0000, 0);
      check("full_model_size", q_addr.size(), 8);
      check("full_valid", ev_valid, 1);
      check("full_head_addr", ev_addr, 0);
      check("full_ovf_before", overflow, 0);
      cycle(1, 4'b0001, 0);
      check("full_ovf", overflow, 1);
      check("full_drop", drop_cnt, 1);
      check("full_head_ts", ev_ts, 0);
      repeat (20) cycle(1, 4'b0000, 1);
      check("drain_count", log_addr.size(), 12);
      if (log_addr.size() == 12) begin
         check("drain_4_addr", log_addr[4], 0);
         check("drain_4_ts", log_ts[4], 5);
         check("drain_11_addr", log_addr[11], 3);
         check("drain_11_ts", log_ts[11], 10);
      end
      check("drain_valid", ev_valid, 0);

      do_reset();
      cycle(1, 4'b0001, 0);
      cycle(1, 4'b0001, 0);
      check("en_pre_valid", ev_valid, 1);
      check("en_pre_ts", ts_now, 2);
      cycle(0, 4'b0001, 1);
      repeat (4) cycle(0, 4'b0011, 1);
      check("en_frozen_ts", ts_now, 2);
      check("en_popped", ev_valid, 0);
      cycle(1, 4'b0011, 1);
      check("en_resume_valid", ev_valid, 0);
      cycle(1, 4'b0011, 1);
      check("en_resume_addr", ev_addr, 1);
      check("en_resume_ts", ev_ts, 2);

      do_reset();
      for (int i = 0; i < 300; i++) cycle(1, (i % 2 == 0) ? 4'b1111 : 4'b0000, 0);
      check("sat_drop", drop_cnt, 255);
      check("sat_model_drop", m_drop, 255);
      check("sat_ovf", overflow, 1);

      do_reset();
      repeat (255) cycle(1, 4'b0000, 1);
      check("wrap_pre_ts", ts_now, 255);
      cycle(1, 4'b0001, 1);
      check("wrap_ts", ts_now, 0);
      cycle(1, 4'b0011, 1);
      repeat (4) cycle(1, 4'b0000, 1);
      check("wrap_count", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         check("wrap_ev0_ts", log_ts[0], 255);
         check("wrap_ev1_addr", log_addr[1], 1);
         check("wrap_ev1_ts", log_ts[1], 0);
      end
      cycle(1, 4'b1100, 0);
      cycle(1, 4'b0000, 0);
      cycle(1, 4'b0001, 0);
      cycle(1, 4'b0000, 0);
      check("rst_q_model", q_addr.size(), 3);
      check("rst_q_valid", ev_valid, 1);
      do_reset();
      check("rst_mid_valid", ev_valid, 0);
      check("rst_mid_ts", ts_now, 0);

      rs = '0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(599) == 0) begin
            do_reset();
            rs = '0;
         end
         flip = '0;
         for (int i = 0; i < N; i++) flip[i] = ($urandom_range(3) == 0);
         rs = rs ^ flip;
         cycle(($urandom_range(9) != 0), rs, ((c / 64) % 3 == 1) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
